// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage: occupancy state encoding,
// main-entry load select, and the difftest sideband beat layout.
// The widths come from config.sv; the guarded defaults below keep this
// package self-contained when it is compiled on its own.
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif
`ifndef INS_WIDTH
`define INS_WIDTH 32
`endif

package pipe_pkg;

    localparam int PIPE_OCC_W = 2;

    // Occupancy of the stage; the encoding equals the number of held beats.
    typedef enum logic [PIPE_OCC_W-1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

    // Where the main entry takes its next value from.
    typedef enum logic [1:0] {
        MAIN_HOLD      = 2'd0,
        MAIN_LOAD_IN   = 2'd1,
        MAIN_LOAD_SKID = 2'd2
    } main_sel_e;

    // Difftest sideband travelling with every beat.
    typedef struct packed {
        logic [`CPU_WIDTH-1:0] pc;
        logic [`INS_WIDTH-1:0] ins;
    } diff_beat_t;

    localparam int DIFF_W = $bits(diff_beat_t);

    // Number of beats held in a given occupancy state.
    function automatic logic [PIPE_OCC_W-1:0] occ_count(input occ_state_e s);
        return (s == OCC_EMPTY) ? 2'd0 : (s == OCC_ONE) ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/config.sv
// Core-wide width configuration shared by the pipeline stages.
// CPU_WIDTH : architectural register / pc width
// INS_WIDTH : instruction word width
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif
`ifndef INS_WIDTH
`define INS_WIDTH 32
`endif

// File: rtl/stl_reg.sv
// Generic enable register with asynchronous active-high reset.
// Used for the main and skid entries of pipe_skid_stage.
module stl_reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load d when enabled, otherwise hold; reset forces RESET_VAL.
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage with a two-entry skid buffer (main + skid).
// Upstream ready is derived from flops only, so backpressure does not ripple
// combinationally through the pipe. Includes a synchronous flush and a
// saturating stall counter.
// Optional feature macro: PIPE_DIFFTEST_EN adds the difftest pc/instruction
// sideband, stored and moved with each beat exactly like the payload.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,   // active-high despite the name
    input  logic                   i_flush,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [WIDTH-1:0]       i_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [WIDTH-1:0]       o_data,
`ifdef PIPE_DIFFTEST_EN
    input  logic [`CPU_WIDTH-1:0]  s_in_diffpc,
    input  logic [`INS_WIDTH-1:0]  s_in_diffins,
    output logic [`CPU_WIDTH-1:0]  s_out_diffpc,
    output logic [`INS_WIDTH-1:0]  s_out_diffins,
`endif
    output logic [PIPE_OCC_W-1:0]  o_occ,
    output logic [CNT_W-1:0]       o_stall_cnt
);

`ifdef PIPE_DIFFTEST_EN
    localparam int BEAT_W = WIDTH + DIFF_W;
    // Sideband occupies the upper bits and always resets/flushes to zero.
    localparam logic [BEAT_W-1:0] BEAT_RESET = {{DIFF_W{1'b0}}, RESET_VAL};
`else
    localparam int BEAT_W = WIDTH;
    localparam logic [BEAT_W-1:0] BEAT_RESET = RESET_VAL;
`endif

    occ_state_e        state_q;
    occ_state_e        state_d;
    main_sel_e         main_sel;
    logic              skid_load;
    logic              main_v;
    logic              skid_v;
    logic              in_fire;
    logic              out_fire;
    logic [BEAT_W-1:0] in_beat;
    logic [BEAT_W-1:0] main_q;
    logic [BEAT_W-1:0] main_d;
    logic [BEAT_W-1:0] skid_q;
    logic [BEAT_W-1:0] skid_d;
    logic              main_en;
    logic              skid_en;
    logic [CNT_W-1:0]  stall_cnt_q;

`ifdef PIPE_DIFFTEST_EN
    diff_beat_t in_diff;
    diff_beat_t out_diff;

    assign in_diff.pc     = s_in_diffpc;
    assign in_diff.ins    = s_in_diffins;
    assign in_beat        = {in_diff, i_data};
    assign out_diff       = main_q[BEAT_W-1:WIDTH];
    assign s_out_diffpc   = out_diff.pc;
    assign s_out_diffins  = out_diff.ins;
`else
    assign in_beat = i_data;
`endif

    // Valid bits are implied by the occupancy state.
    assign main_v   = (state_q != OCC_EMPTY);
    assign skid_v   = (state_q == OCC_FULL);
    assign o_valid  = main_v;
    assign o_ready  = !skid_v;
    assign o_data   = main_q[WIDTH-1:0];
    assign o_occ    = occ_count(state_q);
    assign in_fire  = i_valid && o_ready;
    assign out_fire = main_v && i_ready;

    // Occupancy state register.
    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            state_q <= OCC_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next occupancy and entry-load decisions; flush overrides every transfer.
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        main_sel  = MAIN_HOLD;
        skid_load = 1'b0;
        unique case (state_q)
            OCC_EMPTY: begin
                if (in_fire) begin
                    state_d  = OCC_ONE;
                    main_sel = MAIN_LOAD_IN;
                end
            end
            OCC_ONE: begin
                if (out_fire && in_fire) begin
                    main_sel = MAIN_LOAD_IN;
                end else if (out_fire) begin
                    state_d = OCC_EMPTY;
                end else if (in_fire) begin
                    state_d   = OCC_FULL;
                    skid_load = 1'b1;
                end
            end
            OCC_FULL: begin
                if (out_fire) begin
                    state_d  = OCC_ONE;
                    main_sel = MAIN_LOAD_SKID;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
        if (i_flush) begin
            state_d   = OCC_EMPTY;
            main_sel  = MAIN_HOLD;
            skid_load = 1'b0;
        end
    end

    // Entry write enables and next values; flush reloads both with the reset beat.
    always_comb begin
        main_en = i_flush || (main_sel != MAIN_HOLD);
        skid_en = i_flush || skid_load;
        if (i_flush) begin
            main_d = BEAT_RESET;
        end else if (main_sel == MAIN_LOAD_SKID) begin
            main_d = skid_q;
        end else begin
            main_d = in_beat;
        end
        skid_d = i_flush ? BEAT_RESET : in_beat;
    end

    stl_reg #(
        .WIDTH     (BEAT_W),
        .RESET_VAL (BEAT_RESET)
    ) u_main (
        .clk (i_clk),
        .rst (i_rst_n),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    stl_reg #(
        .WIDTH     (BEAT_W),
        .RESET_VAL (BEAT_RESET)
    ) u_skid (
        .clk (i_clk),
        .rst (i_rst_n),
        .en  (skid_en),
        .d   (skid_d),
        .q   (skid_q)
    );

    // Count cycles where a held beat is refused downstream; saturate at all-ones.
    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            stall_cnt_q <= '0;
        end else if (main_v && !i_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed self-checking bench for pipe_skid_stage: streaming, backpressure,
// flush, async reset, random-ready FIFO ordering and counter saturation.
// Sideband alignment is checked when PIPE_DIFFTEST_EN is defined.
module tb_pipe_skid_stage;

    localparam logic [63:0] RV64 = 64'hDEAD_BEEF_0BAD_F00D;
    localparam logic [7:0]  RV8  = 8'h3C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        i_valid = 1'b0;
    logic [63:0] i_data = '0;
    logic        i_ready = 1'b1;
    logic        o_ready;
    logic        o_valid;
    logic [63:0] o_data;
    logic [1:0]  o_occ;
    logic [31:0] o_stall_cnt;

    logic        v4 = 1'b0;
    logic [7:0]  d4 = '0;
    logic        r4 = 1'b1;
    logic        o_ready4;
    logic        o_valid4;
    logic [7:0]  o_data4;
    logic [1:0]  o_occ4;
    logic [3:0]  o_stall_cnt4;

`ifdef PIPE_DIFFTEST_EN
    logic [`CPU_WIDTH-1:0] in_pc = '0;
    logic [`INS_WIDTH-1:0] in_ins = '0;
    logic [`CPU_WIDTH-1:0] out_pc;
    logic [`INS_WIDTH-1:0] out_ins;
    logic [`CPU_WIDTH-1:0] out_pc4;
    logic [`INS_WIDTH-1:0] out_ins4;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(
        .WIDTH     (64),
        .RESET_VAL (RV64),
        .CNT_W     (32)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_flush     (flush),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data      (i_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
`ifdef PIPE_DIFFTEST_EN
        .s_in_diffpc   (in_pc),
        .s_in_diffins  (in_ins),
        .s_out_diffpc  (out_pc),
        .s_out_diffins (out_ins),
`endif
        .o_occ       (o_occ),
        .o_stall_cnt (o_stall_cnt)
    );

    pipe_skid_stage #(
        .WIDTH     (8),
        .RESET_VAL (RV8),
        .CNT_W     (4)
    ) dut4 (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_flush     (1'b0),
        .i_valid     (v4),
        .o_ready     (o_ready4),
        .i_data      (d4),
        .o_valid     (o_valid4),
        .i_ready     (r4),
        .o_data      (o_data4),
`ifdef PIPE_DIFFTEST_EN
        .s_in_diffpc   ('0),
        .s_in_diffins  ('0),
        .s_out_diffpc  (out_pc4),
        .s_out_diffins (out_ins4),
`endif
        .o_occ       (o_occ4),
        .o_stall_cnt (o_stall_cnt4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one upstream beat; the sideband is derived from the index k.
    task automatic drive(input logic v, input logic [63:0] d, input logic [63:0] k);
        i_valid = v;
        i_data  = d;
`ifdef PIPE_DIFFTEST_EN
        in_pc  = `CPU_WIDTH'(64'h8000_0000 + 4 * k);
        in_ins = `INS_WIDTH'(32'h0000_0013);
`else
        if (k == 64'hFFFF_FFFF_FFFF_FFFF) i_data = d;
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [63:0] q[$];
        logic [63:0] exp_k;
        int          sent;
        int          recv;
        logic        in_f;
        logic        out_f;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_valid", o_valid, 1'b0);
        check("rst_ready", o_ready, 1'b1);
        check("rst_data", o_data, RV64);
        check("rst_occ", o_occ, 2'd0);
        check("rst_stall", o_stall_cnt, 32'd0);
        check("rst_data4", o_data4, RV8);
        rst = 1'b0;
        tick();

        // ---------------- stream 1..8 with i_ready = 1 ----------------
        i_ready = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) begin
                check("stream_valid", o_valid, 1'b1);
                check("stream_data", o_data, 64'(k - 1));
            end
            check("stream_ready", o_ready, 1'b1);
            drive(k <= 8, 64'(k), 64'(k));
            tick();
        end
        check("stream_drained", o_valid, 1'b0);
        check("stream_stall", o_stall_cnt, 32'd0);

        // ---------------- backpressure ----------------
        i_ready = 1'b0;
        drive(1'b1, 64'hA, 64'd10);
        tick();                                   // ONE, main = A
        drive(1'b1, 64'hB, 64'd11);
        tick();                                   // FULL, skid = B, stall 1
        drive(1'b1, 64'hC, 64'd12);
        check("bp_full_occ", o_occ, 2'd2);
        check("bp_full_ready", o_ready, 1'b0);
        check("bp_full_data", o_data, 64'hA);
        tick();                                   // hold, stall 2, C refused
        check("bp_hold_data", o_data, 64'hA);
        check("bp_hold_occ", o_occ, 2'd2);
        i_ready = 1'b1;
        tick();                                   // emit A, main = B
        check("bp_out_b", o_data, 64'hB);
        check("bp_ready_back", o_ready, 1'b1);
        check("bp_occ_one", o_occ, 2'd1);
        tick();                                   // emit B, main = C
        check("bp_out_c", o_data, 64'hC);
        check("bp_valid_c", o_valid, 1'b1);
        drive(1'b0, 64'h0, 64'd0);
        tick();
        check("bp_drained", o_valid, 1'b0);
        check("bp_stall_cnt", o_stall_cnt, 32'd2);

        // ---------------- flush while FULL with i_valid ----------------
        i_ready = 1'b0;
        drive(1'b1, 64'h11, 64'd20);
        tick();                                   // ONE
        drive(1'b1, 64'h22, 64'd21);
        tick();                                   // FULL, stall 3
        check("fl_pre_occ", o_occ, 2'd2);
        drive(1'b1, 64'h33, 64'd22);
        flush = 1'b1;
        tick();                                   // flush, stall 4
        flush = 1'b0;
        drive(1'b0, 64'h0, 64'd0);
        check("fl_valid", o_valid, 1'b0);
        check("fl_occ", o_occ, 2'd0);
        check("fl_ready", o_ready, 1'b1);
        check("fl_data", o_data, RV64);
        check("fl_stall_kept", o_stall_cnt, 32'd4);
        i_ready = 1'b1;
        tick();
        check("fl_no_emit", o_valid, 1'b0);

        // flush in ONE with a same-cycle in_fire: the new beat is discarded
        drive(1'b1, 64'h44, 64'd23);
        tick();
        check("fl1_pre", o_data, 64'h44);
        drive(1'b1, 64'h55, 64'd24);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 64'h0, 64'd0);
        check("fl1_valid", o_valid, 1'b0);
        check("fl1_data", o_data, RV64);

        // ---------------- random i_ready, FIFO order + sideband ----------------
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 400 && recv < 16; cyc++) begin
            drive(sent < 16, 64'h100 + 64'(sent), 64'(sent));
            i_ready = 1'($urandom_range(0, 1));
            #1;
            in_f  = i_valid && o_ready;
            out_f = o_valid && i_ready;
            if (out_f) begin
                exp_k = (q.size() != 0) ? q.pop_front() : 64'hFFFF;
                check("rand_data", o_data, 64'h100 + exp_k);
`ifdef PIPE_DIFFTEST_EN
                check("rand_pc", 64'(out_pc), 64'h8000_0000 + 4 * exp_k);
                check("rand_ins", 64'(out_ins), 64'h13);
`endif
                recv++;
            end
            if (in_f) begin
                q.push_back(64'(sent));
                sent++;
            end
            tick();
        end
        check("rand_count", 64'(recv), 64'd16);
        drive(1'b0, 64'h0, 64'd0);
        i_ready = 1'b1;
        tick();

        // ---------------- async reset while in ONE ----------------
        i_ready = 1'b0;
        drive(1'b1, 64'h77, 64'd30);
        tick();
        drive(1'b0, 64'h0, 64'd0);
        tick();                                   // still ONE, stall advanced
        check("ar_pre_valid", o_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", o_valid, 1'b0);
        check("ar_ready", o_ready, 1'b1);
        check("ar_data", o_data, RV64);
        check("ar_occ", o_occ, 2'd0);
        check("ar_stall", o_stall_cnt, 32'd0);
`ifdef PIPE_DIFFTEST_EN
        check("ar_pc", 64'(out_pc), 64'd0);
`endif
        #1;
        rst = 1'b0;
        i_ready = 1'b1;
        drive(1'b1, 64'h99, 64'd31);
        tick();
        check("ar_after_valid", o_valid, 1'b1);
        check("ar_after_data", o_data, 64'h99);
        drive(1'b0, 64'h0, 64'd0);
        tick();
        check("ar_after_drain", o_valid, 1'b0);

        // ---------------- stall counter saturation, CNT_W = 4 ----------------
        r4 = 1'b0;
        v4 = 1'b1;
        d4 = 8'h5A;
        tick();
        v4 = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) check("sat_14", o_stall_cnt4, 4'd14);
            if (i == 15) check("sat_15", o_stall_cnt4, 4'd15);
        end
        check("sat_final", o_stall_cnt4, 4'd15);
        check("sat_valid", o_valid4, 1'b1);
        check("sat_data", o_data4, 8'h5A);
        check("sat_occ", o_occ4, 2'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised elastic pipeline stage for the in-order core, replacing the fixed per-boundary registers (IF/ID … LS/WB) with one generic block. It holds a payload of WIDTH bits plus valid. A two-entry skid buffer keeps full throughput with a *registered* upstream ready, so ready no longer ripples combinationally back through the pipe. It adds a synchronous flush and a saturating stall counter, and optionally carries the difftest pc/instruction sideband.

## Interface
Parameters:
- WIDTH, 64, payload bits per beat (≥1)
- RESET_VAL, 0, value of stored payload after reset/flush
- CNT_W, 32, stall-counter width

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-high (asserted = 1 despite the name)
- i_flush  in  1  synchronous kill of all held beats
- i_valid  in  1  upstream beat valid
- o_ready  out  1  upstream may transfer; registered
- i_data  in  WIDTH  upstream payload
- o_valid  out  1  downstream beat valid
- i_ready  in  1  downstream accepts
- o_data  out  WIDTH  downstream payload
- o_occ  out  2  beats held (0..2)
- o_stall_cnt  out  CNT_W  cycles with o_valid && !i_ready, saturating
- s_in_diffpc / s_in_diffins  in  `CPU_WIDTH / `INS_WIDTH  difftest sideband (PIPE_DIFFTEST_EN only)
- s_out_diffpc / s_out_diffins  out  `CPU_WIDTH / `INS_WIDTH  sideband aligned with o_data (PIPE_DIFFTEST_EN only)

## Operation
- Storage: main entry (drives outputs) and skid entry, each with a valid bit.
- Transfers: in_fire = i_valid && o_ready; out_fire = o_valid && i_ready.
- o_valid = main_v; o_data = main payload; o_ready = !skid_v (flop-derived only, no dependence on i_ready).
- States by occupancy: EMPTY (0), ONE (main only), FULL (main + skid). The skid entry is never valid without the main entry.
- EMPTY: in_fire → ONE, main ← i_data.
- ONE: out_fire && in_fire → ONE, main ← i_data. out_fire only → EMPTY. in_fire only → FULL, skid ← i_data.
- FULL: o_ready = 0. out_fire → ONE, main ← skid. Otherwise hold.
- Order is strictly FIFO: no beat is dropped or duplicated.
- Flush: i_flush = 1 → next state EMPTY, both valids cleared, payloads ← RESET_VAL. A same-cycle in_fire is discarded. Flush has priority over every transfer. The stall counter is not affected.
- Stall counter: +1 each cycle o_valid && !i_ready. Holds at 2^CNT_W−1. Cleared only by reset.
- o_occ = main_v + skid_v.

## Timing
- Latency: 1 cycle, from in_fire to o_valid, in EMPTY or ONE-with-out_fire.
- Throughput: 1 beat/cycle sustained while i_ready = 1.
- o_ready falls the cycle after the beat that fills the skid entry. It rises the cycle after the out_fire that drains it.
- Reset (async assert): o_valid = 0, o_ready = 1, o_data = RESET_VAL, o_occ = 0, o_stall_cnt = 0, sideband outputs = 0.
- Reset mid-transfer: all held beats are lost, with no partial state. On deassert, the block is in EMPTY and accepts on the next edge.
- i_data is sampled only on in_fire. o_data is stable while o_valid && !i_ready.

## Configuration
- PIPE_DIFFTEST_EN defined: sideband ports exist. Sideband is stored and moved with each beat exactly like the payload (main/skid/flush/reset → 0).
- Not defined: the sideband ports and their storage are absent. Datapath behaviour is identical.

## Structure
- Package pipe_pkg holds:
  - occupancy state enum (EMPTY/ONE/FULL)
  - PIPE_OCC_W = 2
  - a packed beat struct helper for the sideband
- Widths come from config.sv (`CPU_WIDTH, `INS_WIDTH).
- One sub-module: existing stl_reg, instantiated for the main entry and the skid entry. Width is WIDTH plus sideband width when enabled. Each instance gets its own enable/next-value select.

## Test plan
- Stream: WIDTH = 64, i_ready = 1, send 0x1..0x8 back-to-back → o_data 0x1..0x8 one cycle delayed, o_ready always 1, o_stall_cnt = 0.
- Backpressure: send 0xA, 0xB, 0xC with i_ready = 0.
  - 0xA and 0xB are accepted; o_occ = 2; o_ready = 0; 0xC is held upstream.
  - Raise i_ready → output sequence 0xA, 0xB, 0xC.
  - o_stall_cnt equals the number of stalled cycles.
- Flush while FULL, with i_valid = 1 the same cycle → next cycle o_valid = 0, o_occ = 0, o_ready = 1, o_data = RESET_VAL, no beat emitted.
- Async reset asserted mid-cycle while in ONE → outputs take reset values immediately, without waiting for a clock edge. First beat after deassert passes normally.
- Saturation: CNT_W = 4, hold o_valid = 1 with i_ready = 0 for 20 cycles → o_stall_cnt = 15.
- PIPE_DIFFTEST_EN build: beats with pc 0x80000000 + 4k and ins 0x00000013 under random i_ready → s_out_diffpc/s_out_diffins stay aligned with each o_data beat.
